// File: rtl/yarp_mem_arbiter.sv
// yarp_mem_arbiter
//  Shares one unified memory bus between the YARP instruction-fetch port and the
//  data-memory port. One transaction is in flight at a time. The data port wins
//  arbitration by default. After STARVE_LIMIT lost arbitrations, the instruction
//  port is forced to win.
//
//  Ports
//   clk, reset                 clock, synchronous active-high reset
//   i_req_i / i_addr_i         instruction fetch request (held until i_rvalid_o)
//   i_rvalid_o / i_rdata_o     fetch response pulse and data
//   d_req_i / d_addr_i         data request (held until d_rvalid_o)
//   d_wr_i / d_byte_en_i       store flag and size code (00 byte, 01 half, 11 word)
//   d_wr_data_i                store data
//   d_rvalid_o / d_rdata_o     data response/ack pulse and load data
//   mem_req_o .. mem_wr_data_o registered bus request and payload
//   mem_gnt_i                  bus accepted the request
//   mem_rvalid_i / mem_rdata_i bus response
//   err_o                      sticky: bus response seen with nothing outstanding
module yarp_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic        d_wr_i,
  input  logic [1:0]  d_byte_en_i,
  input  logic [31:0] d_wr_data_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [1:0]  mem_byte_en_o,
  output logic [31:0] mem_wr_data_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } owner_e;

  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              mem_wr_q, mem_wr_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic              resp_c;
  logic              i_win_c;

  // State and bus payload registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_D;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  // Arbitration, next state and same-cycle response routing
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wr_d    = mem_wr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    resp_c      = 1'b0;
    // Instruction wins when alone, or when it has lost STARVE_LIMIT times in a row
    i_win_c     = i_req_i && (!d_req_i || (starve_q == StarveMax));

    unique case (state_q)
      ST_IDLE: begin
        if (mem_rvalid_i) begin
          err_d = 1'b1;
        end
        if (i_req_i || d_req_i) begin
          if (i_win_c) begin
            owner_d     = OWN_I;
            mem_addr_d  = i_addr_i;
            mem_wr_d    = 1'b0;
            mem_be_d    = 2'b11;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            owner_d     = OWN_D;
            mem_addr_d  = d_addr_i;
            mem_wr_d    = d_wr_i;
            mem_be_d    = d_byte_en_i;
            mem_wdata_d = d_wr_data_i;
            if (i_req_i && (starve_q != StarveMax)) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end
          mem_req_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          if (mem_rvalid_i) begin
            resp_c  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          resp_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Response pulses are combinational off the bus; reset suppresses them
  always_comb begin
    i_rvalid_o = resp_c && (owner_q == OWN_I) && !reset;
    d_rvalid_o = resp_c && (owner_q == OWN_D) && !reset;
    i_rdata_o  = i_rvalid_o ? mem_rdata_i : '0;
    d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_o      = mem_wr_q;
  assign mem_byte_en_o = mem_be_q;
  assign mem_wr_data_o = mem_wdata_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Testbench for yarp_mem_arbiter: directed scenarios followed by randomized
// requester/bus traffic, checked by a scoreboard monitor sampling on negedge.
module tb_yarp_mem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i;
  logic [31:0] d_addr_i;
  logic        d_wr_i;
  logic [1:0]  d_byte_en_i;
  logic [31:0] d_wr_data_i;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_wr_o;
  logic [1:0]  mem_byte_en_o;
  logic [31:0] mem_wr_data_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  yarp_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_i      (i_req_i),
    .i_addr_i     (i_addr_i),
    .i_rvalid_o   (i_rvalid_o),
    .i_rdata_o    (i_rdata_o),
    .d_req_i      (d_req_i),
    .d_addr_i     (d_addr_i),
    .d_wr_i       (d_wr_i),
    .d_byte_en_i  (d_byte_en_i),
    .d_wr_data_i  (d_wr_data_i),
    .d_rvalid_o   (d_rvalid_o),
    .d_rdata_o    (d_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wr_o     (mem_wr_o),
    .mem_byte_en_o(mem_byte_en_o),
    .mem_wr_data_o(mem_wr_data_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_resp   = 0;

  // Scoreboard queues: bus read data pushed by the stimulus side, grant order by the model
  logic [31:0] rdata_q[$];
  bit          order_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: one transaction in flight, owner and latched fields
  bit          m_active, m_granted, m_own_i, m_err;
  int          m_starve;
  logic [31:0] m_addr, m_wdata, exp_data;
  logic        m_wr;
  logic [1:0]  m_be;
  bit          resp, exp_i, exp_d, win_i;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_i_rvalid", 32'(i_rvalid_o), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid_o), 32'd0);
      m_active  = 0;
      m_granted = 0;
      m_err     = 0;
      m_starve  = 0;
      rdata_q.delete();
    end else begin
      resp = m_active && mem_rvalid_i && (m_granted || mem_gnt_i);
      chk("err_o", 32'(err_o), 32'(m_err));
      chk("mem_req_o", 32'(mem_req_o), 32'(m_active && !m_granted));
      if (m_active) begin
        chk("mem_addr_o", mem_addr_o, m_addr);
        chk("mem_wr_o", 32'(mem_wr_o), 32'(m_wr));
        chk("mem_byte_en_o", 32'(mem_byte_en_o), 32'(m_be));
        chk("mem_wr_data_o", mem_wr_data_o, m_wdata);
      end
      exp_i    = resp && m_own_i;
      exp_d    = resp && !m_own_i;
      exp_data = 32'd0;
      if (resp) begin
        n_resp++;
        if (rdata_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rdata_queue: got empty queue expected pending response at %0t", $time);
        end else begin
          exp_data = rdata_q.pop_front();
        end
      end
      chk("i_rvalid_o", 32'(i_rvalid_o), 32'(exp_i));
      chk("d_rvalid_o", 32'(d_rvalid_o), 32'(exp_d));
      chk("i_rdata_o", i_rdata_o, exp_i ? exp_data : 32'd0);
      chk("d_rdata_o", d_rdata_o, exp_d ? exp_data : 32'd0);

      if (m_active) begin
        if (resp) m_active = 0;
        else if (mem_gnt_i) m_granted = 1;
      end else begin
        if (mem_rvalid_i) m_err = 1;
        if (i_req_i || d_req_i) begin
          win_i = i_req_i && (!d_req_i || m_starve == int'(LIMIT));
          if (win_i) begin
            m_addr   = i_addr_i;
            m_wr     = 1'b0;
            m_be     = 2'b11;
            m_wdata  = 32'd0;
            m_starve = 0;
          end else begin
            m_addr  = d_addr_i;
            m_wr    = d_wr_i;
            m_be    = d_byte_en_i;
            m_wdata = d_wr_data_i;
            if (i_req_i && m_starve < int'(LIMIT)) m_starve++;
          end
          m_own_i   = win_i;
          m_active  = 1;
          m_granted = 0;
          order_q.push_back(win_i);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus responder for directed tests: gw idle cycles before gnt, rvalid rw cycles after gnt
  task automatic bus_txn(input int gw, input int rw, input logic [31:0] data);
    repeat (gw) step();
    mem_gnt_i = 1'b1;
    if (rw == 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = data;
      rdata_q.push_back(data);
    end
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    if (rw > 0) begin
      repeat (rw - 1) step();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = data;
      rdata_q.push_back(data);
      step();
      mem_rvalid_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Random requesters and bus; requests renew only in the cycle after their response
  task automatic run_random(input int ncyc);
    bit i_rv, d_rv, granted, stop;
    int dly, sel;
    granted = 0;
    dly     = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      i_rv = i_rvalid_o;
      d_rv = d_rvalid_o;
      @(posedge clk);
      #1;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      if (granted) begin
        if (dly == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = $urandom;
          rdata_q.push_back(mem_rdata_i);
          granted = 0;
        end else begin
          dly--;
        end
      end else if (mem_req_o && ($urandom_range(0, 1) == 1)) begin
        mem_gnt_i = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = $urandom;
          rdata_q.push_back(mem_rdata_i);
        end else begin
          granted = 1;
          dly     = int'($urandom_range(0, 3));
        end
      end
      stop = (c >= ncyc - 40);
      if (!i_req_i || i_rv) begin
        i_req_i  = !stop && ($urandom_range(0, 9) < 7);
        i_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req_i || d_rv) begin
        d_req_i     = !stop && ($urandom_range(0, 9) < 7);
        d_addr_i    = $urandom;
        d_wr_i      = 1'($urandom_range(0, 1));
        sel         = int'($urandom_range(0, 2));
        d_byte_en_i = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
        d_wr_data_i = $urandom;
      end
    end
  endtask

  bit exp_order[10];
  int resp_before;

  initial begin
    reset        = 1'b1;
    i_req_i      = 1'b0;
    i_addr_i     = 32'd0;
    d_req_i      = 1'b0;
    d_addr_i     = 32'd0;
    d_wr_i       = 1'b0;
    d_byte_en_i  = 2'b00;
    d_wr_data_i  = 32'd0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'd0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("reset_mem_req", 32'(mem_req_o), 32'd0);
    chk("reset_mem_addr", mem_addr_o, 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);

    // Fetch: gnt one cycle after issue, data two cycles later
    i_req_i  = 1'b1;
    i_addr_i = 32'h0000_1000;
    step();
    chk("t1_mem_addr", mem_addr_o, 32'h0000_1000);
    chk("t1_mem_wr", 32'(mem_wr_o), 32'd0);
    bus_txn(0, 2, 32'hDEAD_BEEF);
    i_req_i = 1'b0;
    step();

    // Store with all fields latched onto the bus
    d_req_i     = 1'b1;
    d_wr_i      = 1'b1;
    d_addr_i    = 32'h0000_2004;
    d_byte_en_i = 2'b11;
    d_wr_data_i = 32'h1234_5678;
    step();
    chk("t2_mem_wr", 32'(mem_wr_o), 32'd1);
    chk("t2_mem_wdata", mem_wr_data_o, 32'h1234_5678);
    bus_txn(1, 1, 32'h0);
    d_req_i = 1'b0;
    d_wr_i  = 1'b0;
    step();

    // Grant and response in the same issue cycle
    i_req_i  = 1'b1;
    i_addr_i = 32'h0000_3000;
    step();
    bus_txn(0, 0, 32'hCAFE_F00D);
    i_req_i = 1'b0;
    chk("t4_no_wait", 32'(mem_req_o), 32'd0);
    step();

    // Both ports held, 3-cycle transactions: starvation forces every fifth grant to I
    order_q.delete();
    i_req_i  = 1'b1;
    i_addr_i = 32'h0000_4000;
    d_req_i  = 1'b1;
    d_addr_i = 32'h0000_5000;
    d_wr_i   = 1'b0;
    d_byte_en_i = 2'b01;
    for (int k = 0; k < 10; k++) begin
      step();
      bus_txn(0, 1, $urandom);
    end
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    step();
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    chk("t3_order_len", 32'(order_q.size()), 32'd10);
    for (int k = 0; k < 10 && k < order_q.size(); k++) begin
      chk($sformatf("t3_grant_%0d", k), 32'(order_q[k]), 32'(exp_order[k]));
    end

    // Bus stalls in issue while the data address moves underneath
    d_req_i  = 1'b1;
    d_addr_i = 32'h0000_6000;
    step();
    for (int k = 0; k < 10; k++) begin
      d_addr_i = $urandom;
      step();
    end
    chk("t6_addr_held", mem_addr_o, 32'h0000_6000);
    chk("t6_req_held", 32'(mem_req_o), 32'd1);
    bus_txn(0, 0, 32'h0BAD_F00D);
    d_req_i = 1'b0;
    step();

    // Reset while waiting for data, then a stray bus response
    d_req_i  = 1'b1;
    d_addr_i = 32'h0000_7000;
    step();
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    step();
    reset   = 1'b1;
    d_req_i = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("t5_req_after_reset", 32'(mem_req_o), 32'd0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5555_AAAA;
    step();
    mem_rvalid_i = 1'b0;
    repeat (4) step();
    chk("t5_err_sticky", 32'(err_o), 32'd1);

    do_reset();
    step();
    chk("err_cleared", 32'(err_o), 32'd0);

    resp_before = n_resp;
    run_random(3000);
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    step();
    chk("random_progress", 32'(n_resp - resp_before > 100), 32'd1);
    chk("rdata_q_drained", 32'(rdata_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
